cpu_core: RTL and testbench

CPU_CORE -- requirements
Module: cpu_core

---
 rtl/cpu_core.sv | 190 +++++++++++++++++++
 tb/tb_cpu_core.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
// Multi-cycle accumulator-free register CPU: FETCH -> EXEC -> (MEM) over a single
// request/ready memory port shared by instruction fetch and load/store.
module cpu_core #(
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        NREGS    = 8,
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              i_clock,
  input  logic              i_reset,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  input  logic              i_mem_ready,
  output logic              o_halted
);

  localparam logic [6:0] OpAdd  = 7'd1;
  localparam logic [6:0] OpSub  = 7'd2;
  localparam logic [6:0] OpAnd  = 7'd3;
  localparam logic [6:0] OpOr   = 7'd4;
  localparam logic [6:0] OpXor  = 7'd5;
  localparam logic [6:0] OpLdi  = 7'd6;
  localparam logic [6:0] OpSt   = 7'd7;
  localparam logic [6:0] OpLd   = 7'd8;
  localparam logic [6:0] OpJz   = 7'd9;
  localparam logic [6:0] OpJc   = 7'd10;
  localparam logic [6:0] OpJmp  = 7'd11;
  localparam logic [6:0] OpHalt = 7'd12;

  typedef enum logic [1:0] {StFetch, StExec, StMem, StHalt} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [ADDR_W-1:0]   r_pc;
  logic [31:0]         r_ir;
  logic [DATA_W-1:0]   r_regs [NREGS];
  logic                r_z;
  logic                r_c;

  logic [6:0]          w_op;
  logic [3:0]          w_rd;
  logic [3:0]          w_ra;
  logic [3:0]          w_rb;
  logic [15:0]         w_imm;
  logic [DATA_W-1:0]   w_ra_val;
  logic [DATA_W-1:0]   w_rb_val;
  logic [DATA_W-1:0]   w_rd_val;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_diff;
  logic [DATA_W-1:0]   w_alu;
  logic                w_flags_we;
  logic                w_wb_en;
  logic [DATA_W-1:0]   w_wb_data;
  logic                w_z_next;
  logic                w_c_next;
  logic                w_jump;
  logic [ADDR_W-1:0]   w_target;
  logic                w_rf_we;
  logic [DATA_W-1:0]   w_rf_wdata;
  logic                w_unused;

  // R-type rb and I-type imm deliberately overlap in bits 19:16.
  assign w_op     = r_ir[6:0];
  assign w_rd     = r_ir[11:8];
  assign w_ra     = r_ir[15:12];
  assign w_rb     = r_ir[19:16];
  assign w_imm    = r_ir[31:16];
  assign w_target = ADDR_W'(w_imm);
  assign w_unused = r_ir[7];

  // Out-of-range register indices read as zero.
  always_comb begin
    w_ra_val = '0;
    w_rb_val = '0;
    w_rd_val = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (w_ra == 4'(i)) w_ra_val = r_regs[i];
      if (w_rb == 4'(i)) w_rb_val = r_regs[i];
      if (w_rd == 4'(i)) w_rd_val = r_regs[i];
    end
  end

  assign w_sum  = {1'b0, w_ra_val} + {1'b0, w_rb_val};
  assign w_diff = {1'b0, w_ra_val} - {1'b0, w_rb_val};

  always_comb begin
    w_alu      = '0;
    w_flags_we = 1'b0;
    w_wb_en    = 1'b0;
    w_wb_data  = '0;
    w_z_next   = r_z;
    w_c_next   = r_c;
    w_jump     = 1'b0;
    case (w_op)
      OpAdd: begin w_alu = w_sum[DATA_W-1:0];  w_c_next = w_sum[DATA_W];  w_flags_we = 1'b1; end
      OpSub: begin w_alu = w_diff[DATA_W-1:0]; w_c_next = w_diff[DATA_W]; w_flags_we = 1'b1; end
      OpAnd: begin w_alu = w_ra_val & w_rb_val; w_c_next = 1'b0; w_flags_we = 1'b1; end
      OpOr:  begin w_alu = w_ra_val | w_rb_val; w_c_next = 1'b0; w_flags_we = 1'b1; end
      OpXor: begin w_alu = w_ra_val ^ w_rb_val; w_c_next = 1'b0; w_flags_we = 1'b1; end
      OpLdi: begin
        w_wb_en   = 1'b1;
        w_wb_data = {{(DATA_W-16){w_imm[15]}}, w_imm};
      end
      OpJz:  w_jump = r_z;
      OpJc:  w_jump = r_c;
      OpJmp: w_jump = 1'b1;
      default: ;
    endcase
    if (w_flags_we) begin
      w_wb_en   = 1'b1;
      w_wb_data = w_alu;
      w_z_next  = (w_alu == '0);
    end
  end

  assign w_rf_we    = ((r_state == StExec) && w_wb_en) ||
                      ((r_state == StMem) && i_mem_ready && (w_op == OpLd));
  assign w_rf_wdata = (r_state == StMem) ? i_mem_rdata : w_wb_data;

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= StFetch;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StFetch: if (i_mem_ready) w_state_next = StExec;
      StExec: begin
        if ((w_op == OpLd) || (w_op == OpSt)) w_state_next = StMem;
        else if (w_op == OpHalt)              w_state_next = StHalt;
        else                                  w_state_next = StFetch;
      end
      StMem:   if (i_mem_ready) w_state_next = StFetch;
      StHalt:  w_state_next = StHalt;
      default: w_state_next = StFetch;
    endcase
  end

  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_halted    = 1'b0;
    case (r_state)
      StFetch: begin
        o_mem_req  = 1'b1;
        o_mem_addr = r_pc;
      end
      StMem: begin
        o_mem_req   = 1'b1;
        o_mem_we    = (w_op == OpSt);
        o_mem_addr  = w_ra_val[ADDR_W-1:0];
        o_mem_wdata = w_rd_val;
      end
      StHalt:  o_halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_pc <= RESET_PC;
      r_ir <= '0;
      r_z  <= 1'b0;
      r_c  <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      if ((r_state == StFetch) && i_mem_ready) begin
        r_ir <= i_mem_rdata[31:0];
        r_pc <= r_pc + ADDR_W'(1);
      end
      if (r_state == StExec) begin
        if (w_flags_we) begin
          r_z <= w_z_next;
          r_c <= w_c_next;
        end
        if (w_jump) r_pc <= w_target;
      end
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (w_rf_we && (w_rd == 4'(i))) r_regs[i] <= w_rf_wdata;
      end
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: small programs in a behavioural memory, stores
// captured in a write log, flags observed through taken/not-taken branches.
module tb_cpu_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b0;
  logic [31:0] addr, wdata, rdata;
  logic        req, we, halted;
  logic [31:0] addr4, wdata4, rdata4;
  logic        req4, we4, halted4;

  logic [31:0] mem  [256];
  logic [31:0] mem4 [256];
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_data = '0;

  int          cyc = 0;
  int          wr_cnt = 0;
  int          wr_cnt4 = 0;
  logic [31:0] log_addr [64];
  logic [31:0] log_data [64];
  int          log_cyc  [64];
  logic [31:0] log4_data [64];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rdata  = ovr_en ? ovr_data : mem[addr[7:0]];
  assign rdata4 = mem4[addr4[7:0]];

  cpu_core #(.DATA_W(32), .NREGS(8), .ADDR_W(32), .RESET_PC(32'h0)) dut (
    .i_clock(clk), .i_reset(rst), .o_mem_addr(addr), .o_mem_wdata(wdata),
    .i_mem_rdata(rdata), .o_mem_req(req), .o_mem_we(we), .i_mem_ready(ready),
    .o_halted(halted)
  );

  cpu_core #(.DATA_W(32), .NREGS(4), .ADDR_W(32), .RESET_PC(32'h10)) dut4 (
    .i_clock(clk), .i_reset(rst), .o_mem_addr(addr4), .o_mem_wdata(wdata4),
    .i_mem_rdata(rdata4), .o_mem_req(req4), .o_mem_we(we4), .i_mem_ready(ready),
    .o_halted(halted4)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && req && we && ready) begin
      log_addr[wr_cnt % 64] <= addr;
      log_data[wr_cnt % 64] <= wdata;
      log_cyc[wr_cnt % 64]  <= cyc + 1;
      wr_cnt <= wr_cnt + 1;
    end
    if (!rst && req4 && we4 && ready) begin
      log4_data[wr_cnt4 % 64] <= wdata4;
      wr_cnt4 <= wr_cnt4 + 1;
    end
  end

  function automatic logic [31:0] enc_r(input logic [6:0] op, input logic [3:0] rd,
                                        input logic [3:0] ra, input logic [3:0] rb);
    return {12'h0, rb, ra, rd, 1'b0, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [3:0] rd,
                                        input logic [15:0] imm);
    return {imm, 4'h0, rd, 1'b0, op};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_wr(input int target, input int budget);
    for (int i = 0; i < budget && wr_cnt < target; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    clear_mem();
    ready = 1'b0;
    do_reset();
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL reset_req: got %0b exp 1", req); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b exp 0", we); end
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", addr); end
    checks++; if (wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h exp 0", wdata); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b exp 0", halted); end
    checks++; if (addr4 !== 32'h10) begin errors++; $display("FAIL reset_pc4: got %h exp 10", addr4); end
    step(3);
    checks++; if (req !== 1'b1 || addr !== 32'h0) begin
      errors++; $display("FAIL fetch_stall: got req=%0b addr=%h exp req=1 addr=0", req, addr);
    end
  endtask

  task automatic test_alu_store();
    int base, c0;
    clear_mem();
    mem[0] = enc_i(7'd6, 4'd1, 16'd5);
    mem[1] = enc_i(7'd6, 4'd2, 16'd3);
    mem[2] = enc_r(7'd1, 4'd3, 4'd1, 4'd2);
    mem[3] = enc_r(7'd7, 4'd3, 4'd1, 4'd0);
    mem[4] = enc_i(7'd9, 4'd0, 16'h0030);
    mem[5] = enc_i(7'd10, 4'd0, 16'h0031);
    mem[6] = enc_r(7'd12, 4'd0, 4'd0, 4'd0);
    ready = 1'b1;
    base = wr_cnt;
    do_reset();
    c0 = cyc;
    step(9);
    checks++; if (wr_cnt !== base + 1) begin errors++; $display("FAIL st_count: got %0d exp %0d", wr_cnt, base + 1); end
    checks++; if (log_addr[base % 64] !== 32'd5) begin errors++; $display("FAIL st_addr: got %h exp 5", log_addr[base % 64]); end
    checks++; if (log_data[base % 64] !== 32'd8) begin errors++; $display("FAIL st_data: got %h exp 8", log_data[base % 64]); end
    checks++; if (log_cyc[base % 64] - c0 !== 9) begin errors++; $display("FAIL st_latency: got %0d exp 9", log_cyc[base % 64] - c0); end
    checks++; if (addr !== 32'd4) begin errors++; $display("FAIL after_st_pc: got %h exp 4", addr); end
    step(2);
    checks++; if (addr !== 32'd5) begin errors++; $display("FAIL jz_not_taken: got %h exp 5", addr); end
    step(2);
    checks++; if (addr !== 32'd6) begin errors++; $display("FAIL jc_not_taken: got %h exp 6", addr); end
    step(2);
    checks++; if (halted !== 1'b1 || req !== 1'b0) begin
      errors++; $display("FAIL halt_enter: got halted=%0b req=%0b exp 1 0", halted, req);
    end
    step(3);
    checks++; if (halted !== 1'b1 || req !== 1'b0) begin
      errors++; $display("FAIL halt_stay: got halted=%0b req=%0b exp 1 0", halted, req);
    end
  endtask

  task automatic test_add_carry();
    int base;
    clear_mem();
    mem[0]     = enc_i(7'd6, 4'd1, 16'hFFFF);
    mem[1]     = enc_i(7'd6, 4'd2, 16'd1);
    mem[2]     = enc_r(7'd1, 4'd3, 4'd1, 4'd2);
    mem[3]     = enc_i(7'd9, 4'd0, 16'h0040);
    mem[8'h40] = enc_i(7'd10, 4'd0, 16'h0050);
    mem[8'h50] = enc_r(7'd7, 4'd3, 4'd0, 4'd0);
    mem[8'h51] = enc_r(7'd12, 4'd0, 4'd0, 4'd0);
    ready = 1'b1;
    base = wr_cnt;
    do_reset();
    step(8);
    checks++; if (addr !== 32'h40) begin errors++; $display("FAIL jz_taken: got %h exp 40", addr); end
    step(2);
    checks++; if (addr !== 32'h50) begin errors++; $display("FAIL jc_carry: got %h exp 50", addr); end
    step(3);
    checks++; if (wr_cnt !== base + 1) begin errors++; $display("FAIL carry_st_count: got %0d exp %0d", wr_cnt, base + 1); end
    checks++; if (log_data[base % 64] !== 32'h0) begin errors++; $display("FAIL add_wrap: got %h exp 0", log_data[base % 64]); end
  endtask

  task automatic test_ld_wait();
    int base;
    clear_mem();
    mem[0]     = enc_r(7'd8, 4'd4, 4'd0, 4'd0);
    mem[1]     = enc_r(7'd7, 4'd4, 4'd0, 4'd0);
    mem[2]     = enc_i(7'd6, 4'd5, 16'h0020);
    mem[3]     = enc_r(7'd8, 4'd5, 4'd5, 4'd0);
    mem[4]     = enc_r(7'd7, 4'd5, 4'd0, 4'd0);
    mem[5]     = enc_r(7'd12, 4'd0, 4'd0, 4'd0);
    mem[8'h20] = 32'h1234_5678;
    ready = 1'b1;
    base = wr_cnt;
    do_reset();
    step(2);
    ready = 1'b0;
    ovr_en = 1'b1;
    ovr_data = 32'hDEAD_BEEF;
    checks++; if (req !== 1'b1 || we !== 1'b0 || addr !== 32'h0) begin
      errors++; $display("FAIL ld_issue: got req=%0b we=%0b addr=%h exp 1 0 0", req, we, addr);
    end
    for (int k = 0; k < 3; k++) begin
      step(1);
      checks++; if (req !== 1'b1 || addr !== 32'h0) begin
        errors++; $display("FAIL ld_hold%0d: got req=%0b addr=%h exp 1 0", k, req, addr);
      end
    end
    ready = 1'b1;
    step(1);
    ovr_en = 1'b0;
    checks++; if (addr !== 32'h1 || we !== 1'b0) begin
      errors++; $display("FAIL ld_next_fetch: got addr=%h we=%0b exp 1 0", addr, we);
    end
    step(2);
    checks++; if (we !== 1'b1 || wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL st_drive: got we=%0b wdata=%h exp 1 deadbeef", we, wdata);
    end
    step(1);
    checks++; if (wr_cnt !== base + 1 || log_data[base % 64] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ld_value: got cnt=%0d data=%h exp %0d deadbeef", wr_cnt, log_data[base % 64], base + 1);
    end
    wait_wr(base + 2, 40);
    checks++; if (wr_cnt !== base + 2) begin errors++; $display("FAIL ld_alias_count: got %0d exp %0d", wr_cnt, base + 2); end
    checks++; if (log_data[(base + 1) % 64] !== 32'h1234_5678) begin
      errors++; $display("FAIL ld_alias_data: got %h exp 12345678", log_data[(base + 1) % 64]);
    end
  endtask

  task automatic test_sub_borrow();
    int base;
    clear_mem();
    mem[0]     = enc_i(7'd6, 4'd2, 16'd1);
    mem[1]     = enc_r(7'd2, 4'd1, 4'd0, 4'd2);
    mem[2]     = enc_i(7'd10, 4'd0, 16'h0010);
    mem[8'h10] = enc_i(7'd9, 4'd0, 16'h0020);
    mem[8'h11] = enc_r(7'd7, 4'd1, 4'd0, 4'd0);
    mem[8'h12] = enc_r(7'd12, 4'd0, 4'd0, 4'd0);
    ready = 1'b1;
    base = wr_cnt;
    do_reset();
    step(6);
    checks++; if (addr !== 32'h10) begin errors++; $display("FAIL jc_borrow: got %h exp 10", addr); end
    step(2);
    checks++; if (addr !== 32'h11) begin errors++; $display("FAIL sub_z_clear: got %h exp 11", addr); end
    step(3);
    checks++; if (wr_cnt !== base + 1 || log_data[base % 64] !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL sub_result: got cnt=%0d data=%h exp %0d ffffffff", wr_cnt, log_data[base % 64], base + 1);
    end
  endtask

  task automatic test_logic();
    int base;
    clear_mem();
    mem[0]     = enc_i(7'd6, 4'd1, 16'h00F0);
    mem[1]     = enc_i(7'd6, 4'd2, 16'h0FF0);
    mem[2]     = enc_r(7'd2, 4'd3, 4'd0, 4'd2);
    mem[3]     = enc_r(7'd5, 4'd4, 4'd1, 4'd2);
    mem[4]     = enc_i(7'd10, 4'd0, 16'h0030);
    mem[5]     = enc_r(7'd3, 4'd5, 4'd1, 4'd2);
    mem[6]     = enc_r(7'd4, 4'd6, 4'd1, 4'd2);
    mem[7]     = enc_r(7'd5, 4'd7, 4'd6, 4'd6);
    mem[8]     = enc_i(7'd9, 4'd0, 16'h0040);
    mem[8'h40] = enc_r(7'd7, 4'd4, 4'd0, 4'd0);
    mem[8'h41] = enc_r(7'd7, 4'd5, 4'd1, 4'd0);
    mem[8'h42] = enc_r(7'd7, 4'd6, 4'd2, 4'd0);
    mem[8'h43] = enc_r(7'd12, 4'd0, 4'd0, 4'd0);
    ready = 1'b1;
    base = wr_cnt;
    do_reset();
    step(10);
    checks++; if (addr !== 32'h5) begin errors++; $display("FAIL xor_clears_c: got %h exp 5", addr); end
    step(8);
    checks++; if (addr !== 32'h40) begin errors++; $display("FAIL xor_zero_z: got %h exp 40", addr); end
    wait_wr(base + 3, 40);
    checks++; if (wr_cnt !== base + 3) begin errors++; $display("FAIL logic_count: got %0d exp %0d", wr_cnt, base + 3); end
    checks++; if (log_data[base % 64] !== 32'h0F00) begin errors++; $display("FAIL xor_val: got %h exp 0f00", log_data[base % 64]); end
    checks++; if (log_addr[(base + 1) % 64] !== 32'hF0 || log_data[(base + 1) % 64] !== 32'h00F0) begin
      errors++; $display("FAIL and_val: got a=%h d=%h exp f0 f0", log_addr[(base + 1) % 64], log_data[(base + 1) % 64]);
    end
    checks++; if (log_addr[(base + 2) % 64] !== 32'hFF0 || log_data[(base + 2) % 64] !== 32'h0FF0) begin
      errors++; $display("FAIL or_val: got a=%h d=%h exp ff0 ff0", log_addr[(base + 2) % 64], log_data[(base + 2) % 64]);
    end
  endtask

  task automatic test_nregs4();
    int base4;
    ready = 1'b1;
    base4 = wr_cnt4;
    do_reset();
    for (int i = 0; i < 60 && wr_cnt4 < base4 + 3; i++) @(negedge clk);
    checks++; if (wr_cnt4 !== base4 + 3) begin errors++; $display("FAIL n4_count: got %0d exp %0d", wr_cnt4, base4 + 3); end
    checks++; if (log4_data[base4 % 64] !== 32'h0) begin errors++; $display("FAIL n4_add: got %h exp 0", log4_data[base4 % 64]); end
    checks++; if (log4_data[(base4 + 1) % 64] !== 32'h0) begin errors++; $display("FAIL n4_r7: got %h exp 0", log4_data[(base4 + 1) % 64]); end
    checks++; if (log4_data[(base4 + 2) % 64] !== 32'h7) begin errors++; $display("FAIL n4_r3: got %h exp 7", log4_data[(base4 + 2) % 64]); end
    step(3);
    checks++; if (halted4 !== 1'b1) begin errors++; $display("FAIL n4_halt: got %0b exp 1", halted4); end
  endtask

  task automatic test_reset_mid();
    int base;
    clear_mem();
    mem[0]     = enc_i(7'd6, 4'd1, 16'h0022);
    mem[1]     = enc_r(7'd8, 4'd1, 4'd1, 4'd0);
    mem[8'h22] = 32'h0000_0099;
    ready = 1'b1;
    do_reset();
    step(4);
    ready = 1'b0;
    checks++; if (req !== 1'b1 || we !== 1'b0 || addr !== 32'h22) begin
      errors++; $display("FAIL mid_ld_addr: got req=%0b we=%0b addr=%h exp 1 0 22", req, we, addr);
    end
    step(1);
    mem[0] = enc_r(7'd7, 4'd1, 4'd0, 4'd0);
    mem[1] = enc_r(7'd12, 4'd0, 4'd0, 4'd0);
    base = wr_cnt;
    do_reset();
    ready = 1'b1;
    step(3);
    checks++; if (wr_cnt !== base + 1 || log_data[base % 64] !== 32'h0) begin
      errors++; $display("FAIL mid_abandon: got cnt=%0d data=%h exp %0d 0", wr_cnt, log_data[base % 64], base + 1);
    end
  endtask

  task automatic test_halt_reset();
    clear_mem();
    mem[0] = enc_r(7'd12, 4'd0, 4'd0, 4'd0);
    ready = 1'b1;
    do_reset();
    step(2);
    checks++; if (halted !== 1'b1 || req !== 1'b0) begin
      errors++; $display("FAIL hr_halt: got halted=%0b req=%0b exp 1 0", halted, req);
    end
    step(3);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL hr_stay: got %0b exp 1", halted); end
    do_reset();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL hr_unhalt: got %0b exp 0", halted); end
    checks++; if (req !== 1'b1 || addr !== 32'h0) begin
      errors++; $display("FAIL hr_refetch: got req=%0b addr=%h exp 1 0", req, addr);
    end
    checks++; if (addr4 !== 32'h10) begin errors++; $display("FAIL hr_pc4: got %h exp 10", addr4); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem4[i] = '0;
    mem4[8'h10] = enc_i(7'd6, 4'd7, 16'd9);
    mem4[8'h11] = enc_r(7'd1, 4'd1, 4'd7, 4'd0);
    mem4[8'h12] = enc_r(7'd7, 4'd1, 4'd0, 4'd0);
    mem4[8'h13] = enc_i(7'd9, 4'd0, 16'h0018);
    mem4[8'h18] = enc_r(7'd7, 4'd7, 4'd0, 4'd0);
    mem4[8'h19] = enc_i(7'd6, 4'd3, 16'd7);
    mem4[8'h1A] = enc_r(7'd7, 4'd3, 4'd0, 4'd0);
    mem4[8'h1B] = enc_r(7'd12, 4'd0, 4'd0, 4'd0);
    test_reset();
    test_alu_store();
    test_add_carry();
    test_ld_wait();
    test_sub_borrow();
    test_logic();
    test_nregs4();
    test_reset_mid();
    test_halt_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout exp finish");
    $fatal(1);
  end

endmodule
